// File: rtl/retro1_pad_pkg.sv
// Shared types and constants for the Retro-1 serial pad poller.
package retro1_pad_pkg;

  localparam int PAD_BITS_DEFAULT = 16;

  // Button positions in the parallel word (serial bit order of the pad)
  localparam int B      = 0;
  localparam int Y      = 1;
  localparam int SELECT = 2;
  localparam int START  = 3;
  localparam int UP     = 4;
  localparam int DOWN   = 5;
  localparam int LEFT   = 6;
  localparam int RIGHT  = 7;
  localparam int A      = 8;
  localparam int X      = 9;
  localparam int L      = 10;
  localparam int R      = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_DONE     = 3'd4
  } pad_state_e;

endpackage

// File: rtl/retro1_sync2.sv
// Generic two-flop synchroniser; resets to the idle level of the line.
module retro1_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of an asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/retro1_pad_poller.sv
// SNES-style serial pad poller: latch, clock out POLL_BITS bits, present them
// as an active-high button word with a one-cycle Valid strobe.
module retro1_pad_poller
  import retro1_pad_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int LATCH_TICKS = 2,
  parameter int POLL_BITS   = PAD_BITS_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Pause,
  input  logic                 Poll,
  input  logic                 PadData,
  output logic                 PadLatch,
  output logic                 PadClk,
  output logic [POLL_BITS-1:0] Buttons,
  output logic                 Valid,
  output logic                 Busy
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(POLL_BITS);
  localparam int LW = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;

  pad_state_e           state, state_nxt;
  logic [DW-1:0]        div;
  logic [BW-1:0]        bit_cnt;
  logic [LW-1:0]        lat_cnt;
  logic [POLL_BITS-1:0] shreg;
  logic                 pad_sync;
  logic                 div_last, bit_last, lat_last, accept;

  retro1_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (Clk),
    .rst (Reset),
    .d   (PadData),
    .q   (pad_sync)
  );

  assign div_last = (div == DW'(CLK_DIV - 1));
  assign bit_last = (bit_cnt == BW'(POLL_BITS - 1));
  assign lat_last = (lat_cnt == LW'(LATCH_TICKS - 1));
  // DONE is not busy, so a poll there starts the next one back-to-back
  assign accept   = ((state == ST_IDLE) || (state == ST_DONE)) && Poll && !Pause;

  // Next-state decode; every timed state ends on the last divider cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: state_nxt = accept ? ST_LATCH : ST_IDLE;
      ST_LATCH:         if (div_last && lat_last) state_nxt = ST_SHIFT_HI;
      ST_SHIFT_HI:      if (div_last) state_nxt = ST_SHIFT_LO;
      ST_SHIFT_LO:      if (div_last) state_nxt = bit_last ? ST_DONE : ST_SHIFT_HI;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // State, divider, bit/latch counters and the deserialising shift register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      lat_cnt <= '0;
      shreg   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        div     <= '0;
        bit_cnt <= '0;
        lat_cnt <= '0;
        shreg   <= '0;
      end else if (state == ST_LATCH || state == ST_SHIFT_HI || state == ST_SHIFT_LO) begin
        div <= div_last ? '0 : div + DW'(1);
        if (state == ST_LATCH && div_last)
          lat_cnt <= lat_last ? '0 : lat_cnt + LW'(1);
        // Bits arrive LSB first: shifting in at the top leaves bit 0 at the bottom
        if (state == ST_SHIFT_HI && div_last)
          shreg <= {~pad_sync, shreg[POLL_BITS-1:1]};
        if (state == ST_SHIFT_LO && div_last && !bit_last)
          bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  // Outputs are registered from the next state so they align with it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PadLatch <= 1'b0;
      PadClk   <= 1'b1;
      Busy     <= 1'b0;
      Valid    <= 1'b0;
      Buttons  <= '0;
    end else begin
      PadLatch <= (state_nxt == ST_LATCH);
      PadClk   <= (state_nxt != ST_SHIFT_LO);
      Busy     <= (state_nxt == ST_LATCH) || (state_nxt == ST_SHIFT_HI) ||
                  (state_nxt == ST_SHIFT_LO);
      Valid    <= (state_nxt == ST_DONE);
      if (state_nxt == ST_DONE) Buttons <= shreg;
    end
  end

endmodule

// File: tb/tb_retro1_pad_poller.sv
// Bench for retro1_pad_poller: pad model, timing-formula reference model
// checked every cycle, plus directed literal checks.
module tb_retro1_pad_poller;

  localparam int D   = 4;
  localparam int LT  = 2;
  localparam int N   = 16;
  localparam int LD  = LT * D;
  localparam int LAT = 1 + D * (LT + 2 * N);   // 137

  logic          Clk = 1'b0, Reset = 1'b1, Pause = 1'b0, Poll = 1'b0, PadData = 1'b1;
  logic          PadLatch, PadClk, Valid, Busy;
  logic [N-1:0]  Buttons;

  retro1_pad_poller #(.CLK_DIV(D), .LATCH_TICKS(LT), .POLL_BITS(N)) dut (
    .Clk(Clk), .Reset(Reset), .Pause(Pause), .Poll(Poll), .PadData(PadData),
    .PadLatch(PadLatch), .PadClk(PadClk), .Buttons(Buttons), .Valid(Valid), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [N-1:0] pat_cur = 16'hFFFF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Pad: parallel-loads on latch, advances one cycle after each PadClk rise
  logic [N-1:0] sh = '1;
  logic         pad_prev = 1'b1;
  initial begin
    forever begin
      @(negedge Clk);
      if (Reset) begin
        sh = '1; PadData = 1'b1;
      end else if (PadLatch) begin
        sh = pat_cur; PadData = sh[0];
      end else if (!pad_prev && PadClk) begin
        @(posedge Clk); #1;
        sh = {1'b1, sh[N-1:1]}; PadData = sh[0];
      end
      pad_prev = PadClk;
    end
  end

  // Reference model: t = cycles since acceptance (-1 when idle)
  int           t = -1;
  logic [N-1:0] m_btn = '0, m_pat = '0;
  int           latch_cnt = 0, fall_cnt = 0;
  logic         mon_prev = 1'b1;
  int           vq[$];
  logic [N-1:0] bq[$];

  always @(negedge Clk) begin
    if (Reset) begin
      t = -1; m_btn = '0;
      chk("rst_latch", PadLatch, 0);
      chk("rst_padclk", PadClk, 1);
      chk("rst_busy", Busy, 0);
      chk("rst_valid", Valid, 0);
      chk("rst_buttons", Buttons, 0);
    end else begin
      if (t == LAT) m_btn = ~m_pat;
      chk("latch", PadLatch, (t >= 1 && t <= LD));
      chk("padclk", PadClk, !(t > LD && t < LAT && ((t - LD - 1) % (2 * D)) >= D));
      chk("busy", Busy, (t >= 1 && t < LAT));
      chk("valid", Valid, (t == LAT));
      chk("buttons", Buttons, m_btn);
      if (t >= 1 && t < LAT) t++;
      else if (Poll && !Pause) begin t = 1; m_pat = pat_cur; end
      else t = -1;
    end
    if (PadLatch) latch_cnt++;
    if (mon_prev && !PadClk) fall_cnt++;
    mon_prev = PadClk;
    if (Valid) begin vq.push_back(cyc); bq.push_back(Buttons); end
  end

  task automatic tick(); @(posedge Clk); #1; endtask
  task automatic clr(); vq.delete(); bq.delete(); latch_cnt = 0; fall_cnt = 0; endtask

  int acc;
  initial begin
    repeat (3) tick();
    Reset = 0;
    repeat (2) tick();

    // B pressed only
    clr(); pat_cur = 16'hFFFE; acc = cyc;
    Poll = 1; tick(); Poll = 0;
    repeat (145) tick();
    chk("t1_nvalid", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("t1_lat", vq[0] - acc, 137);
      chk("t1_btn", bq[0], 16'h0001);
    end
    chk("t1_latch_cycles", latch_cnt, 8);
    chk("t1_clk_pulses", fall_cnt, 16);

    // Back-to-back: second poll accepted in the DONE cycle
    clr(); pat_cur = 16'h5A5A; acc = cyc;
    Poll = 1; tick(); Poll = 0;
    repeat (20) tick();
    pat_cur = 16'hFFFF;
    repeat (116) tick();
    Poll = 1; tick(); Poll = 0;
    repeat (150) tick();
    chk("t2_nvalid", vq.size(), 2);
    if (vq.size() > 1) begin
      chk("t2_lat0", vq[0] - acc, 137);
      chk("t2_lat1", vq[1] - acc, 274);
      chk("t2_btn0", bq[0], 16'hA5A5);
      chk("t2_btn1", bq[1], 16'h0000);
    end

    // Poll held high for 51 cycles: one poll only
    clr(); pat_cur = 16'h1234; acc = cyc;
    Poll = 1; repeat (51) tick(); Poll = 0;
    repeat (100) tick();
    chk("t3_nvalid", vq.size(), 1);
    if (vq.size() > 0) chk("t3_lat", vq[0] - acc, 137);

    // Pause together with Poll: rejected
    clr();
    Pause = 1; Poll = 1; tick(); Poll = 0; Pause = 0;
    chk("t4_busy", Busy, 0);
    chk("t4_latch", PadLatch, 0);
    repeat (3) tick();
    chk("t4_nvalid", vq.size(), 0);

    // Pause rising mid-poll: no effect
    clr(); pat_cur = 16'h1234; acc = cyc;
    Poll = 1; tick(); Poll = 0;
    repeat (39) tick();
    Pause = 1;
    repeat (110) tick();
    Pause = 0;
    repeat (5) tick();
    chk("t5_nvalid", vq.size(), 1);
    if (vq.size() > 0) begin
      chk("t5_lat", vq[0] - acc, 137);
      chk("t5_btn", bq[0], 16'hEDCB);
    end

    // Reset mid-poll at cycle 60
    clr(); pat_cur = 16'h0F0F;
    Poll = 1; tick(); Poll = 0;
    repeat (59) tick();
    Reset = 1; #1;
    chk("t6_padclk", PadClk, 1);
    chk("t6_latch", PadLatch, 0);
    chk("t6_busy", Busy, 0);
    chk("t6_buttons", Buttons, 0);
    repeat (2) tick();
    Reset = 0;
    repeat (150) tick();
    chk("t6_nvalid", vq.size(), 0);

    // Random patterns, ignored polls/pauses while busy, random gaps
    clr();
    for (int p = 0; p < 100; p++) begin
      pat_cur = N'($urandom);
      Poll = 1; tick(); Poll = 0;
      for (int k = 1; k < LAT; k++) begin
        if (k < 130) begin
          Poll  = ($urandom_range(0, 3) == 0);
          Pause = ($urandom_range(0, 3) == 0);
        end else begin
          Poll = 0; Pause = 0;
        end
        tick();
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (150) tick();
    chk("t7_nvalid", vq.size(), 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/retro1_pad_poller.md
# retro1_pad_poller

Serial game-controller poller that sits between the core's controller pins and a Retro-1 core. On request it drives the latch/clock strobes of a shift-register pad (SNES-style, active-low serial data), deserialises the returned bits and presents them to the core as an active-high parallel button word with a one-cycle valid strobe. The core issues `Poll` once per frame, typically at vblank, and consumes `Buttons` when `Valid` pulses.

## Interface
- `CLK_DIV`, 4: `Clk` cycles per pad half-period (one divider tick); must be ≥ 4.
- `LATCH_TICKS`, 2: number of ticks `PadLatch` is held high.
- `POLL_BITS`, 16: serial bits shifted per poll.

- `Clk`  in  1  system clock; the only clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `Pause`  in  1  level-sensitive; while high, new polls are not accepted.
- `Poll`  in  1  request a poll; accepted only when `Busy`=0 and `Pause`=0.
- `PadData`  in  1  serial data from the pad; asynchronous; active-low (0 = pressed).
- `PadLatch`  out  1  parallel-load strobe to the pad, active-high.
- `PadClk`  out  1  shift clock to the pad; idles high.
- `Buttons`  out  POLL_BITS  last completed poll; bit i = i-th serial bit, inverted (1 = pressed).
- `Valid`  out  1  one-cycle pulse when `Buttons` updates.
- `Busy`  out  1  poll in progress.

## Operation
- Reset values: `PadLatch`=0, `PadClk`=1, `Buttons`=0, `Valid`=0, `Busy`=0, FSM=IDLE, counters=0.
- `PadData` passes through a 2-flop synchroniser before any use.
- FSM states: IDLE, LATCH, SHIFT_HI, SHIFT_LO, DONE.
  - IDLE: `Poll`&&!`Pause` -> LATCH; clear the shift register, bit counter and divider.
  - LATCH: `PadLatch`=1 for LATCH_TICKS·CLK_DIV cycles -> SHIFT_HI (bit 0).
  - SHIFT_HI: `PadClk`=1 for CLK_DIV cycles; on the last cycle, shift in the inverted synchronised data as bit i -> SHIFT_LO.
  - SHIFT_LO: `PadClk`=0 for CLK_DIV cycles; the rising edge at the end advances the pad. Then SHIFT_HI with i+1, or DONE if i = POLL_BITS-1.
  - DONE: one cycle. `Buttons` <= shift register, `Valid`=1, `Busy`=0 -> IDLE.
- A `Poll` received while `Busy`=1 is ignored and not queued.
- Simultaneous `Poll` and `Pause`: not accepted. A `Pause` that rises mid-poll has no effect; the poll completes and `Valid` still pulses.
- A `Poll` in the DONE cycle is accepted; polls may run back-to-back.
- When `Reset` is asserted mid-poll, all outputs take their reset values immediately and the partial data is discarded.
- Divider counts 0..CLK_DIV-1 with width $clog2(CLK_DIV). Bit counter width is $clog2(POLL_BITS). Neither wraps outside the active states.

## Timing
- Acceptance cycle = cycle 0, D = CLK_DIV, L = LATCH_TICKS, N = POLL_BITS.
- `Busy`=1 in cycles 1..L·D+2·D·N.
- `PadLatch`=1 in cycles 1..L·D.
- Bit i:
  - `PadClk`=1 in cycles L·D+1+2Di .. L·D+D+2Di.
  - Sample taken in cycle L·D+D+2Di.
  - `PadClk`=0 in the following D cycles.
- `Valid`=1 and `Buttons` new in cycle L·D+2·D·N+1; latency = 1+D·(L+2N).
- `PadData` must be stable at the pin from 1 cycle after the `PadClk` rising edge until the sample cycle, a window of D-1 cycles including synchroniser delay.
- `Buttons` holds its value between `Valid` pulses. All outputs are registered.

## Structure
- Package `retro1_pad_pkg`:
  - state enum `pad_state_e`;
  - `PAD_BITS_DEFAULT`=16;
  - button index constants B=0, Y=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7, A=8, X=9, L=10, R=11.
- Sub-module `retro1_sync2`: generic 2-flop synchroniser with async reset, reset value 1 (idle-high line).

## Test plan
- Defaults (D=4, L=2, N=16). Pad model returns serial pattern 0xFFFE (bit 0 low = B pressed); `Poll` in cycle 0 -> `PadLatch` high in cycles 1..8, 16 `PadClk` low pulses, `Valid` in cycle 137, `Buttons`=0x0001.
- Pattern 0x5A5A, then a second poll accepted in the DONE cycle with pattern 0xFFFF -> `Buttons`=0xA5A5 at cycle 137, then 0x0000 at cycle 274.
- `Poll` held high in cycles 0..50 -> exactly one poll and one `Valid` in cycle 137; no second poll started.
- `Pause`=1 with `Poll` in cycle 0 -> nothing starts, `Busy`=0. `Pause` rising at cycle 40 of an accepted poll -> poll completes, `Valid` in cycle 137.
- `Reset` asserted at cycle 60 -> in the same cycle `PadClk`=1, `PadLatch`=0, `Busy`=0, `Buttons`=0; no `Valid` follows.
- Pad data changes 1 cycle after each `PadClk` rising edge -> every bit is sampled correctly; a reference model compares all 16 bits over 100 random patterns.
